regfile_seq_engine: RTL and testbench

- Client-side sequencer for the 32x64 register file. Drives the register file's write port (RegWrite/RD/WriteData) and its RS1 read port.
- Two jobs. First, a bulk initialisation that writes INIT_VAL into every register. Second, a debug dump that reads every register in order and streams it out over a valid/ready handshake.
- Sits beside the datapath and owns the register-file ports only while busy. Top-level muxing onto the register file is outside this block.

---
 rtl/regfile_seq_engine.sv | 143 ++++++++++++++
 tb/tb_regfile_seq_engine.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq_engine.sv
// regfile_seq_engine
// Client-side sequencer for the register file. It owns the register file's
// write port and RS1 read port while busy and runs one of two sweeps:
//   - init: writes INIT_VAL into every register, one register per cycle
//   - dump: reads every register in order and streams it out over a
//           valid/ready handshake, one beat per register
// Ports:
//   clk, reset (async, active-low)
//   init_start, dump_start        one-cycle sweep requests (init wins a tie)
//   busy, done                    sweep in progress / one-cycle completion pulse
//   RegWrite, RD, WriteData       register file write port
//   RS1, ReadData1                register file read port (data valid after the
//                                 negedge that follows an RS1 change)
//   dump_valid, dump_ready        dump beat handshake
//   dump_addr, dump_data, dump_last  dump beat payload
// Every output is a flop, so the register file and the dump sink never see
// combinational paths from this block.
module regfile_seq_engine #(
  parameter int                 NUM_REGS = 32,
  parameter int                 ADDR_W   = 5,
  parameter int                 DATA_W   = 64,
  parameter logic [DATA_W-1:0]  INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_start,
  input  logic              dump_start,
  output logic              busy,
  output logic              done,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] WriteData,
  output logic [ADDR_W-1:0] RS1,
  input  logic [DATA_W-1:0] ReadData1,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_INIT     = 2'd1;
  localparam logic [1:0] ST_DUMP_RD  = 2'd2;
  localparam logic [1:0] ST_DUMP_OUT = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] idx_nxt_s;
  logic              idx_last_s;

  // Next sweep index and end-of-sweep detect; idx never passes LAST_IDX.
  always_comb begin
    idx_nxt_s  = idx_r + IDX_ONE;
    idx_last_s = (idx_r == LAST_IDX);
  end

  // Sweep sequencer: state, index and every registered output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      idx_r      <= IDX_ZERO;
      busy       <= 1'b0;
      done       <= 1'b0;
      RegWrite   <= 1'b0;
      RD         <= IDX_ZERO;
      WriteData  <= {DATA_W{1'b0}};
      RS1        <= IDX_ZERO;
      dump_valid <= 1'b0;
      dump_addr  <= IDX_ZERO;
      dump_data  <= {DATA_W{1'b0}};
      dump_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Starts are only looked at here, so requests while busy are dropped.
          if (init_start) begin
            state_r   <= ST_INIT;
            idx_r     <= IDX_ZERO;
            busy      <= 1'b1;
            RegWrite  <= 1'b1;
            RD        <= IDX_ZERO;
            WriteData <= INIT_VAL;
          end else if (dump_start) begin
            state_r <= ST_DUMP_RD;
            idx_r   <= IDX_ZERO;
            busy    <= 1'b1;
            RS1     <= IDX_ZERO;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_INIT: begin
          if (idx_last_s) begin
            state_r  <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            RegWrite <= 1'b0;
          end else begin
            idx_r <= idx_nxt_s;
            RD    <= idx_nxt_s;
          end
        end
        ST_DUMP_RD: begin
          // RS1 has been stable for a full cycle, so ReadData1 is settled.
          state_r    <= ST_DUMP_OUT;
          dump_valid <= 1'b1;
          dump_addr  <= idx_r;
          dump_data  <= ReadData1;
          dump_last  <= idx_last_s;
        end
        ST_DUMP_OUT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (idx_last_s) begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r <= ST_DUMP_RD;
              idx_r   <= idx_nxt_s;
              RS1     <= idx_nxt_s;
            end
          end else begin
            state_r <= ST_DUMP_OUT;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          busy       <= 1'b0;
          RegWrite   <= 1'b0;
          dump_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq_engine.sv
// Bench for regfile_seq_engine. Two engines run in lockstep from the same
// stimulus: u0 with the default INIT_VAL (0) and u1 with 64'hDEAD_BEEF_CAFE_F00D.
// Each drives its own emulated register file (write and read on negedge).
// A sweep-level model predicts every output each cycle; a beat collector
// records accepted dump beats for sweep-level checks.
module tb_regfile_seq_engine;

  localparam int N = 32;

  typedef struct {
    int          cyc;
    logic        last;
    logic [4:0]  addr;
    logic [63:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init_start = 1'b0;
  logic        dump_start = 1'b0;
  logic        dump_ready = 1'b1;

  logic [1:0]  busy_v, done_v, rw_v, dv_v, dl_v;
  logic [4:0]  rd_v [2];
  logic [4:0]  rs1_v [2];
  logic [4:0]  da_v [2];
  logic [63:0] wd_v [2];
  logic [63:0] dd_v [2];
  logic [63:0] rdata_v [2];

  logic [63:0] x [2][N];
  logic [1:0]  pre_sel = 2'd0;
  int          bp_mode = 0;
  int          hold7 = 0;
  int          stall7 = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  beat_t       q0[$];
  beat_t       q1[$];

  // model state and expected outputs
  int          m_mode [2];
  int          m_k [2];
  bit          m_beat [2];
  logic        e_busy [2], e_done [2], e_we [2], e_dv [2], e_dl [2];
  logic [4:0]  e_rd [2], e_rs1 [2], e_da [2];
  logic [63:0] e_wd [2], e_dd [2];

  regfile_seq_engine u0 (
    .clk(clk), .reset(reset), .init_start(init_start), .dump_start(dump_start),
    .busy(busy_v[0]), .done(done_v[0]), .RegWrite(rw_v[0]), .RD(rd_v[0]),
    .WriteData(wd_v[0]), .RS1(rs1_v[0]), .ReadData1(rdata_v[0]),
    .dump_valid(dv_v[0]), .dump_ready(dump_ready), .dump_addr(da_v[0]),
    .dump_data(dd_v[0]), .dump_last(dl_v[0])
  );

  regfile_seq_engine #(.INIT_VAL(64'hDEAD_BEEF_CAFE_F00D)) u1 (
    .clk(clk), .reset(reset), .init_start(init_start), .dump_start(dump_start),
    .busy(busy_v[1]), .done(done_v[1]), .RegWrite(rw_v[1]), .RD(rd_v[1]),
    .WriteData(wd_v[1]), .RS1(rs1_v[1]), .ReadData1(rdata_v[1]),
    .dump_valid(dv_v[1]), .dump_ready(dump_ready), .dump_addr(da_v[1]),
    .dump_data(dd_v[1]), .dump_last(dl_v[1])
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] iv_of(input int j);
    return (j == 0) ? 64'd0 : 64'hDEAD_BEEF_CAFE_F00D;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // emulated register file: commits writes and samples RS1 on negedge
  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (pre_sel == 2'd1) begin
        for (int i = 0; i < N; i++) x[j][i] <= 64'(i) + 64'd100;
      end else if (pre_sel == 2'd2) begin
        for (int i = 0; i < N; i++) x[j][i] <= 64'hA5A5_0000_0000_0000 + 64'(i);
      end else if (rw_v[j]) begin
        x[j][rd_v[j]] <= wd_v[j];
      end
      rdata_v[j] <= x[j][rs1_v[j]];
    end
  end

  always @(posedge clk) cyc++;

  // sweep-level model: which sweep is running, which register, beat shown
  always @(posedge clk or negedge reset) begin
    for (int j = 0; j < 2; j++) begin
      if (!reset) begin
        m_mode[j] = 0; m_k[j] = 0; m_beat[j] = 1'b0;
        e_busy[j] = 1'b0; e_done[j] = 1'b0; e_we[j] = 1'b0; e_dv[j] = 1'b0;
        e_dl[j] = 1'b0; e_rd[j] = 5'd0; e_rs1[j] = 5'd0; e_da[j] = 5'd0;
        e_wd[j] = 64'd0; e_dd[j] = 64'd0;
      end else begin
        e_done[j] = 1'b0;
        if (m_mode[j] == 0) begin
          if (init_start) begin
            m_mode[j] = 1; m_k[j] = 0; e_we[j] = 1'b1; e_rd[j] = 5'd0; e_wd[j] = iv_of(j);
          end else if (dump_start) begin
            m_mode[j] = 2; m_k[j] = 0; m_beat[j] = 1'b0; e_rs1[j] = 5'd0;
          end
        end else if (m_mode[j] == 1) begin
          if (m_k[j] == N - 1) begin
            e_we[j] = 1'b0; e_done[j] = 1'b1; m_mode[j] = 0;
          end else begin
            m_k[j]++; e_rd[j] = 5'(m_k[j]);
          end
        end else if (!m_beat[j]) begin
          e_dv[j] = 1'b1; e_da[j] = 5'(m_k[j]); e_dd[j] = x[j][m_k[j]];
          e_dl[j] = (m_k[j] == N - 1); m_beat[j] = 1'b1;
        end else if (dump_ready) begin
          e_dv[j] = 1'b0; m_beat[j] = 1'b0;
          if (m_k[j] == N - 1) begin
            e_done[j] = 1'b1; m_mode[j] = 0;
          end else begin
            m_k[j]++; e_rs1[j] = 5'(m_k[j]);
          end
        end
        e_busy[j] = (m_mode[j] != 0);
      end
    end
  end

  // per-cycle compare of both engines against the model
  always @(posedge clk) begin
    #1;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("u%0d.busy", j), 64'(busy_v[j]), 64'(e_busy[j]));
      chk($sformatf("u%0d.done", j), 64'(done_v[j]), 64'(e_done[j]));
      chk($sformatf("u%0d.RegWrite", j), 64'(rw_v[j]), 64'(e_we[j]));
      chk($sformatf("u%0d.RD", j), 64'(rd_v[j]), 64'(e_rd[j]));
      chk($sformatf("u%0d.WriteData", j), wd_v[j], e_wd[j]);
      chk($sformatf("u%0d.RS1", j), 64'(rs1_v[j]), 64'(e_rs1[j]));
      chk($sformatf("u%0d.dump_valid", j), 64'(dv_v[j]), 64'(e_dv[j]));
      chk($sformatf("u%0d.dump_addr", j), 64'(da_v[j]), 64'(e_da[j]));
      chk($sformatf("u%0d.dump_data", j), dd_v[j], e_dd[j]);
      chk($sformatf("u%0d.dump_last", j), 64'(dl_v[j]), 64'(e_dl[j]));
    end
  end

  // dump_ready driver: tied high, random, or a 5-cycle stall on beat 7
  always @(negedge clk) begin
    #1;
    if (bp_mode == 1) begin
      dump_ready = ($urandom_range(0, 1) == 1);
    end else if (bp_mode == 2 && dv_v[0] && da_v[0] == 5'd7 && hold7 < 5) begin
      dump_ready = 1'b0;
      hold7++;
    end else begin
      dump_ready = 1'b1;
    end
    if (bp_mode != 2) hold7 = 0;
  end

  // beat collector: a beat is accepted when valid and ready meet at posedge
  always @(negedge clk) begin
    #2;
    if (dv_v[0] && dump_ready) q0.push_back('{cyc, dl_v[0], da_v[0], dd_v[0]});
    if (dv_v[1] && dump_ready) q1.push_back('{cyc, dl_v[1], da_v[1], dd_v[1]});
    if (dv_v[0] && !dump_ready && da_v[0] == 5'd7) stall7++;
  end

  task automatic preload(input logic [1:0] k);
    @(negedge clk); #1 pre_sel = k;
    @(negedge clk); #1 pre_sel = 2'd0;
  endtask

  task automatic pulse(input logic ini, input logic dmp);
    @(negedge clk); #1;
    init_start = ini; dump_start = dmp;
    @(posedge clk); #2;
    init_start = 1'b0; dump_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy_v[0] && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= budget) chk({nm, "_timeout"}, 64'(busy_v[0]), 64'd0);
  endtask

  // kind 0: INIT_VAL of that engine, kind 2: A5A5 pattern
  task automatic check_dump(input string nm, input int j, input int kind, input bit spacing);
    int sz;
    beat_t b, pb;
    logic [63:0] e;
    sz = (j == 0) ? q0.size() : q1.size();
    chk({nm, "_beats"}, 64'(sz), 64'(N));
    for (int i = 0; i < sz; i++) begin
      b = (j == 0) ? q0[i] : q1[i];
      e = (kind == 0) ? iv_of(j) : 64'hA5A5_0000_0000_0000 + 64'(i);
      chk($sformatf("%s_addr%0d", nm, i), 64'(b.addr), 64'(i));
      chk($sformatf("%s_data%0d", nm, i), b.data, e);
      chk($sformatf("%s_last%0d", nm, i), 64'(b.last), 64'(i == N - 1));
      if (spacing && i > 0) begin
        pb = (j == 0) ? q0[i-1] : q1[i-1];
        chk($sformatf("%s_gap%0d", nm, i), 64'(b.cyc - pb.cyc), 64'd2);
      end
    end
  endtask

  initial begin
    int we_cnt, done_at;
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    int we_cnt, done_at;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy_v), 64'd0);
    chk("reset_dump_valid", 64'(dv_v), 64'd0);
    @(negedge clk); #1 reset = 1'b1;

    // init sweep over preloaded i+100
    preload(2'd1);
    we_cnt = 0; done_at = 0;
    @(negedge clk); #1 init_start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #2;
      if (c == 1) init_start = 1'b0;
      if (rw_v[0]) we_cnt++;
      if (done_v[0] && done_at == 0) done_at = c;
    end
    chk("init_we_cycles", 64'(we_cnt), 64'd32);
    chk("init_done_cycle", 64'(done_at), 64'd33);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("init_u0_x%0d", i), x[0][i], 64'd0);
      chk($sformatf("init_u1_x%0d", i), x[1][i], 64'hDEAD_BEEF_CAFE_F00D);
    end

    // dump with dump_ready tied high
    preload(2'd2);
    bp_mode = 0; q0.delete(); q1.delete();
    pulse(1'b0, 1'b1);
    wait_idle("dump_plain", 200);
    check_dump("dump_plain", 0, 2, 1'b1);

    // backpressure on beat 7
    bp_mode = 2; stall7 = 0; q0.delete(); q1.delete();
    pulse(1'b0, 1'b1);
    wait_idle("dump_bp", 200);
    check_dump("dump_bp", 0, 2, 1'b0);
    chk("dump_bp_stall7", 64'(stall7), 64'd5);
    bp_mode = 0;

    // simultaneous starts: init only, no beats
    preload(2'd1);
    q0.delete(); q1.delete();
    pulse(1'b1, 1'b1);
    wait_idle("arb_both", 100);
    chk("arb_both_beats", 64'(q0.size()), 64'd0);
    chk("arb_both_x31", x[0][31], 64'd0);

    // dump_start during init is dropped
    preload(2'd1);
    pulse(1'b1, 1'b0);
    repeat (5) @(posedge clk);
    pulse(1'b0, 1'b1);
    wait_idle("arb_mid", 100);
    repeat (3) @(posedge clk);
    #2;
    chk("arb_mid_beats", 64'(q0.size()), 64'd0);
    chk("arb_mid_busy", 64'(busy_v), 64'd0);

    // reset during init after register 10 is written
    preload(2'd1);
    pulse(1'b1, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk); #2 reset = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy_v), 64'd0);
    chk("rst_mid_we", 64'(rw_v), 64'd0);
    chk("rst_mid_done", 64'(done_v), 64'd0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_mid_u0_x%0d", i), x[0][i], (i <= 10) ? 64'd0 : 64'(i) + 64'd100);
      chk($sformatf("rst_mid_u1_x%0d", i), x[1][i],
          (i <= 10) ? 64'hDEAD_BEEF_CAFE_F00D : 64'(i) + 64'd100);
    end
    @(negedge clk); #1 reset = 1'b1;
    pulse(1'b1, 1'b0);
    wait_idle("rst_reinit", 100);
    for (int i = 0; i < N; i += 7) chk($sformatf("rst_reinit_x%0d", i), x[0][i], 64'd0);

    // dump after init shows each engine's INIT_VAL, random backpressure
    bp_mode = 1; q0.delete(); q1.delete();
    pulse(1'b0, 1'b1);
    wait_idle("dump_iv", 400);
    check_dump("dump_iv_u0", 0, 0, 1'b0);
    check_dump("dump_iv_u1", 1, 0, 1'b0);

    // random start requests and backpressure, checked by the model
    for (int n = 0; n < 600; n++) begin
      @(negedge clk); #1;
      init_start = ($urandom_range(0, 19) == 0);
      dump_start = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk); #1 init_start = 1'b0; dump_start = 1'b0;
    wait_idle("random", 400);

    repeat (2) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
